// File: rtl/sram_bank_arbiter.sv
// Two-port arbiter for four 1K x 16 SRAM banks (CPU + Wishbone).
// CPU-priority grant with bounded Wishbone starvation.
module sram_bank_arbiter #(
  parameter int AW         = 12,
  parameter int DW         = 16,
  parameter int NBANK      = 4,
  parameter int RD_LAT     = 1,
  parameter int WB_MAXWAIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [AW-1:0]       cpu_addr,
  input  logic [DW-1:0]       cpu_wdata,
  output logic [DW-1:0]       cpu_rdata,
  output logic                cpu_ack,
  input  logic                wb_req,
  input  logic                wb_we,
  input  logic [AW-1:0]       wb_addr,
  input  logic [DW-1:0]       wb_wdata,
  output logic [DW-1:0]       wb_rdata,
  output logic                wb_ack,
  output logic [NBANK-1:0]    mem_csb,
  output logic                mem_web,
  output logic [AW-3:0]       mem_addr,
  output logic [DW-1:0]       mem_wdata,
  input  logic [NBANK*DW-1:0] mem_rdata
);

  localparam int RW = AW - 2;
  localparam int CW = $clog2(WB_MAXWAIT + 1);
  localparam logic [CW-1:0] MAXW = CW'(WB_MAXWAIT);
  localparam logic [1:0] LAST = 2'(RD_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t        state_q, state_d;
  logic          own_wb_q, own_wb_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [CW-1:0] starve_q, starve_d;
  logic [NBANK-1:0] csb_q, csb_d;
  logic          web_q, web_d;
  logic [RW-1:0] maddr_q, maddr_d;
  logic [DW-1:0] mwdata_q, mwdata_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          wb_ack_q, wb_ack_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] wb_rdata_q, wb_rdata_d;

  logic          gnt_cpu, gnt_wb;
  logic          g_we;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wdata;
  logic [DW-1:0] rd_slice;

  // WB only overtakes a pending CPU request once it has lost enough rounds
  assign gnt_cpu = cpu_req & ~(wb_req & (starve_q == MAXW));
  assign gnt_wb  = wb_req & ~gnt_cpu;
  assign g_we    = gnt_wb ? wb_we    : cpu_we;
  assign g_addr  = gnt_wb ? wb_addr  : cpu_addr;
  assign g_wdata = gnt_wb ? wb_wdata : cpu_wdata;

  always_comb begin
    rd_slice = '0;
    for (int b = 0; b < NBANK; b++) begin
      if (addr_q[AW-1 -: 2] == 2'(b)) begin
        rd_slice = mem_rdata[b*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    own_wb_d    = own_wb_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    csb_d       = '1;
    web_d       = 1'b1;
    maddr_d     = maddr_q;
    mwdata_d    = mwdata_q;
    cpu_ack_d   = 1'b0;
    wb_ack_d    = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    wb_rdata_d  = wb_rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_cpu || gnt_wb) begin
          state_d  = ST_ACCESS;
          own_wb_d = gnt_wb;
          we_d     = g_we;
          addr_d   = g_addr;
          wdata_d  = g_wdata;
          for (int b = 0; b < NBANK; b++) begin
            csb_d[b] = (g_addr[AW-1 -: 2] != 2'(b));
          end
          web_d    = ~g_we;
          maddr_d  = g_addr[RW-1:0];
          mwdata_d = g_wdata;
          if (gnt_wb) begin
            starve_d = '0;
          end else if (wb_req && starve_q != MAXW) begin
            starve_d = starve_q + 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        cnt_d = '0;
        if (we_q) begin
          state_d   = ST_RESP;
          cpu_ack_d = ~own_wb_q;
          wb_ack_d  = own_wb_q;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == LAST) begin
          state_d   = ST_RESP;
          cpu_ack_d = ~own_wb_q;
          wb_ack_d  = own_wb_q;
          if (own_wb_q) begin
            wb_rdata_d = rd_slice;
          end else begin
            cpu_rdata_d = rd_slice;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      own_wb_q    <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      starve_q    <= '0;
      csb_q       <= '1;
      web_q       <= 1'b1;
      maddr_q     <= '0;
      mwdata_q    <= '0;
      cpu_ack_q   <= 1'b0;
      wb_ack_q    <= 1'b0;
      cpu_rdata_q <= '0;
      wb_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      own_wb_q    <= own_wb_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      csb_q       <= csb_d;
      web_q       <= web_d;
      maddr_q     <= maddr_d;
      mwdata_q    <= mwdata_d;
      cpu_ack_q   <= cpu_ack_d;
      wb_ack_q    <= wb_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      wb_rdata_q  <= wb_rdata_d;
    end
  end

  assign mem_csb   = csb_q;
  assign mem_web   = web_q;
  assign mem_addr  = maddr_q;
  assign mem_wdata = mwdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign wb_ack    = wb_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign wb_rdata  = wb_rdata_q;

endmodule
